// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: opcodes, datapath selects and the
// registered bundle carried from decode to execute.
package decode_stage_pkg;

    localparam logic [6:0] OPC_L     = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRL = 3'b101;

    typedef enum logic [1:0] {
        PC_INCR,
        PC_IMM_OFFSET,
        PC_ALU_OUT
    } pc_sel_t;

    typedef enum logic [1:0] {
        REG_WR_ALU,
        REG_WR_MEM,
        REG_WR_PC,
        REG_WR_IMM
    } reg_wr_sel_t;

    typedef enum logic {
        ALU_OPND_REG,
        ALU_OPND_IMM
    } alu_opnd_sel_t;

    typedef enum logic {
        ALU_OPND1_REG,
        ALU_OPND1_PC
    } alu_opnd1_sel_t;

    // Every 4-bit code is named so decoded values never fall outside the enum
    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_OR,
        ALU_AND,
        ALU_SUB,
        ALU_RSV9,
        ALU_BR_LT,
        ALU_BR_LTU,
        ALU_RSV12,
        ALU_SRA,
        ALU_RSV14,
        ALU_RSV15
    } alu_optr_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_I_SHIFT,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_JAL
    } imm_decoder_sel_t;

    typedef struct packed {
        pc_sel_t        pc_sel;
        reg_wr_sel_t    reg_wr_sel;
        alu_opnd_sel_t  alu_opnd_sel;
        alu_opnd1_sel_t alu_opnd1_sel;
        alu_optr_t      alu_optr;
        logic           branch;
        logic [2:0]     br_funct3;
        logic           reg_wr_en;
        logic           mem_wr_en;
        logic           mem_rd_en;
        logic [2:0]     mem_width;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [4:0]     rd;
        logic           illegal;
    } id_ex_t;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return opc == OPC_R || opc == OPC_S || opc == OPC_B;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: picks the RV32I immediate
// format and sign-extends it to XLEN.
module decode_stage_imm_gen
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]      instr,
    input  imm_decoder_sel_t sel,
    output logic [XLEN-1:0]  imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        unique case (sel)
            IMM_I:       imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_I_SHIFT: imm32 = {27'd0, instr[24:20]};
            IMM_S:       imm32 = {{20{instr[31]}}, instr[31:25],
                                  instr[11:7]};
            IMM_B:       imm32 = {{20{instr[31]}}, instr[7],
                                  instr[30:25], instr[11:8], 1'b0};
            IMM_U:       imm32 = {instr[31:12], 12'd0};
            IMM_JAL:     imm32 = {{12{instr[31]}}, instr[19:12],
                                  instr[20], instr[30:21], 1'b0};
            default:     imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshakes,
// load-use bubble insertion, flush and a saturating bubble counter.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter bit          ENABLE_UPPER  = 1'b1,
    parameter bit          HAZARD_DETECT = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic [31:0]       i_instr,
    input  logic [XLEN-1:0]   i_pc,
    input  logic              i_flush,
    output logic              o_dec_valid,
    input  logic              i_dec_ready,
    output logic [XLEN-1:0]   o_pc,
    output pc_sel_t           o_pc_sel,
    output reg_wr_sel_t       o_reg_wr_sel,
    output alu_opnd_sel_t     o_alu_opnd_sel,
    output alu_opnd1_sel_t    o_alu_opnd1_sel,
    output alu_optr_t         o_alu_optr,
    output logic              o_branch,
    output logic [2:0]        o_br_funct3,
    output logic              o_reg_wr_en,
    output logic              o_mem_wr_en,
    output logic              o_mem_rd_en,
    output logic [2:0]        o_mem_width,
    output logic [4:0]        o_rs1,
    output logic [4:0]        o_rs2,
    output logic [4:0]        o_rd,
    output logic [XLEN-1:0]   o_imm,
    output logic              o_illegal,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q;
    id_ex_t           dec_d;
    id_ex_t           dec_q;
    imm_decoder_sel_t imm_sel;
    logic [XLEN-1:0]  imm_d;
    logic [XLEN-1:0]  imm_q;
    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] cnt_q;

    logic [6:0] opc;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       full;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       hazard;
    logic       accept;
    logic       out_fire;

    assign opc      = i_instr[6:0];
    assign funct3   = i_instr[14:12];
    assign funct7_5 = i_instr[30];

    always_comb begin
        dec_d     = '0;
        imm_sel   = IMM_I;
        dec_d.rs1 = i_instr[19:15];
        dec_d.rs2 = i_instr[24:20];
        dec_d.rd  = i_instr[11:7];
        unique case (1'b1)
            opc == OPC_L: begin
                dec_d.alu_opnd_sel = ALU_OPND_IMM;
                dec_d.reg_wr_sel   = REG_WR_MEM;
                dec_d.reg_wr_en    = 1'b1;
                dec_d.mem_rd_en    = 1'b1;
                dec_d.mem_width    = funct3;
            end
            opc == OPC_S: begin
                dec_d.alu_opnd_sel = ALU_OPND_IMM;
                dec_d.mem_wr_en    = 1'b1;
                dec_d.mem_width    = funct3;
                imm_sel            = IMM_S;
            end
            opc == OPC_I: begin
                dec_d.alu_opnd_sel = ALU_OPND_IMM;
                dec_d.reg_wr_en    = 1'b1;
                dec_d.alu_optr     = alu_optr_t'({
                    (funct3 == F3_SRL) ? funct7_5 : 1'b0, funct3});
                if (funct3 == F3_SLL || funct3 == F3_SRL)
                    imm_sel = IMM_I_SHIFT;
            end
            opc == OPC_R: begin
                dec_d.reg_wr_en = 1'b1;
                dec_d.alu_optr  = alu_optr_t'({funct7_5, funct3});
            end
            opc == OPC_B: begin
                // Execute resolves the condition and gates pc_sel
                dec_d.branch    = 1'b1;
                dec_d.br_funct3 = funct3;
                dec_d.pc_sel    = PC_IMM_OFFSET;
                dec_d.alu_optr  = alu_optr_t'({2'b10, funct3[2:1]});
                imm_sel         = IMM_B;
            end
            opc == OPC_JAL: begin
                dec_d.pc_sel     = PC_IMM_OFFSET;
                dec_d.reg_wr_sel = REG_WR_PC;
                dec_d.reg_wr_en  = 1'b1;
                imm_sel          = IMM_JAL;
            end
            opc == OPC_JALR: begin
                dec_d.pc_sel       = PC_ALU_OUT;
                dec_d.alu_opnd_sel = ALU_OPND_IMM;
                dec_d.reg_wr_sel   = REG_WR_PC;
                dec_d.reg_wr_en    = 1'b1;
            end
            (opc == OPC_LUI) && ENABLE_UPPER: begin
                dec_d.reg_wr_sel = REG_WR_IMM;
                dec_d.reg_wr_en  = 1'b1;
                imm_sel          = IMM_U;
            end
            (opc == OPC_AUIPC) && ENABLE_UPPER: begin
                dec_d.alu_opnd1_sel = ALU_OPND1_PC;
                dec_d.alu_opnd_sel  = ALU_OPND_IMM;
                dec_d.reg_wr_en     = 1'b1;
                imm_sel             = IMM_U;
            end
            default: dec_d.illegal = 1'b1;
        endcase
    end

    decode_stage_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (i_instr),
        .sel   (imm_sel),
        .imm   (imm_d)
    );

    assign full    = (state_q == ST_FULL);
    assign rs1_hit = uses_rs1(opc) && (i_instr[19:15] == dec_q.rd);
    assign rs2_hit = uses_rs2(opc) && (i_instr[24:20] == dec_q.rd);

    assign hazard = HAZARD_DETECT && full && dec_q.mem_rd_en &&
                    (dec_q.rd != 5'd0) && i_instr_valid &&
                    (rs1_hit || rs2_hit);

    assign o_instr_ready = i_flush ||
                           ((!full || i_dec_ready) && !hazard);
    assign accept        = i_instr_valid && o_instr_ready && !i_flush;
    assign out_fire      = full && i_dec_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            dec_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (i_flush) begin
                state_q <= ST_EMPTY;
            end else if (accept) begin
                state_q <= ST_FULL;
                dec_q   <= dec_d;
                imm_q   <= imm_d;
                pc_q    <= i_pc;
            end else if (out_fire) begin
                state_q <= ST_EMPTY;
            end
            // Load leaving while its consumer waits opens the bubble
            if (!i_flush && out_fire && hazard && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_dec_valid     = full;
    assign o_pc            = pc_q;
    assign o_pc_sel        = dec_q.pc_sel;
    assign o_reg_wr_sel    = dec_q.reg_wr_sel;
    assign o_alu_opnd_sel  = dec_q.alu_opnd_sel;
    assign o_alu_opnd1_sel = dec_q.alu_opnd1_sel;
    assign o_alu_optr      = dec_q.alu_optr;
    assign o_branch        = dec_q.branch;
    assign o_br_funct3     = dec_q.br_funct3;
    assign o_reg_wr_en     = dec_q.reg_wr_en;
    assign o_mem_wr_en     = dec_q.mem_wr_en;
    assign o_mem_rd_en     = dec_q.mem_rd_en;
    assign o_mem_width     = dec_q.mem_width;
    assign o_rs1           = dec_q.rs1;
    assign o_rs2           = dec_q.rs2;
    assign o_rd            = dec_q.rd;
    assign o_imm           = imm_q;
    assign o_illegal       = dec_q.illegal;
    assign o_bubble_cnt    = cnt_q;

endmodule
